// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative unsigned MULTU/DIVU controller that borrows the EX-stage ALU for one
// operation per cycle and delivers the 64-bit result in HI/LO.
//
// Build option: MULDIV_DIV_EN
//   defined   - DIVU runs as a restoring divide (compare cycle + subtract cycle per bit)
//   undefined - divide hardware is absent; an accepted DIVU completes at once with HI=LO=0
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   start, op          request strobe, 0 = MULTU / 1 = DIVU
//   rs_val, rt_val     multiplicand/dividend, multiplier/divisor
//   alu_req            block owns the ALU this cycle
//   alu_a, alu_b       ALU operands (0 when not owning the ALU)
//   alu_ctrl           ALU control code (0 when not owning the ALU)
//   alu_result         combinational ALU result for the current operands
//   busy               pipeline stall while iterating
//   done               one-cycle pulse, hi/lo hold the new result
//   hi, lo             HI/LO result registers
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// MUL     | shift-add step: P_hi + (P_lo[0] ? M : 0), then shift right
// DIV_CMP | shift remainder left, compare against divisor (SLT)
// DIV_SUB | subtract divisor when it fits, set quotient bit
// DONE    | result visible on hi/lo, done pulse, may accept next start
module muldiv_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [3:0] ALU_ADD = 4'b0010,
    parameter logic [3:0] ALU_SUB = 4'b0110,
    parameter logic [3:0] ALU_SLT = 4'b0111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             alu_req,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MULDIV_DIV_EN
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_CMP, S_DIV_SUB, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;
`endif

    localparam logic [4:0] CNT_LAST = 5'(WIDTH - 1);

    state_t           state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] m;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;

    logic             mul_carry;
    logic [WIDTH-1:0] mul_hi_nx;
    logic [WIDTH-1:0] mul_lo_nx;

`ifdef MULDIV_DIV_EN
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;     // holds the shifted remainder Rs while in DIV_SUB
    logic             ovf;   // bit shifted out of r: Rs really exceeds WIDTH bits
    logic             lt;
    logic             take;
    logic [WIDTH-1:0] r_nx;
    logic [WIDTH-1:0] q_nx;
`endif

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = '0;
        case (state)
            S_MUL: begin
                alu_a    = p_hi;
                alu_b    = p_lo[0] ? m : '0;
                alu_ctrl = ALU_ADD;
            end
`ifdef MULDIV_DIV_EN
            S_DIV_CMP: begin
                alu_a    = {r[WIDTH-2:0], q[WIDTH-1]};
                alu_b    = d;
                alu_ctrl = ALU_SLT;
            end
            S_DIV_SUB: begin
                alu_a    = r;
                alu_b    = d;
                alu_ctrl = ALU_SUB;
            end
`endif
            default: ;
        endcase
    end

    // The ALU has no carry-out, so an unsigned wrap of the add is detected here.
    assign mul_carry = (alu_result < p_hi);
    assign mul_hi_nx = {mul_carry, alu_result[WIDTH-1:1]};
    assign mul_lo_nx = {alu_result[0], p_lo[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    assign take = ovf | ~lt;
    assign r_nx = take ? alu_result : r;
    assign q_nx = {q[WIDTH-1:1], take};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            m       <= '0;
            p_hi    <= '0;
            p_lo    <= '0;
            alu_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MULDIV_DIV_EN
            d       <= '0;
            q       <= '0;
            r       <= '0;
            ovf     <= 1'b0;
            lt      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        cnt <= '0;
                        if (!op) begin
                            m       <= rs_val;
                            p_lo    <= rt_val;
                            p_hi    <= '0;
                            busy    <= 1'b1;
                            alu_req <= 1'b1;
                            state   <= S_MUL;
                        end else begin
`ifdef MULDIV_DIV_EN
                            d <= rt_val;
                            q <= rs_val;
                            r <= '0;
                            if (rt_val == '0) begin
                                hi    <= rs_val;
                                lo    <= '1;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                busy    <= 1'b1;
                                alu_req <= 1'b1;
                                state   <= S_DIV_CMP;
                            end
`else
                            hi    <= '0;
                            lo    <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
`endif
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    p_hi <= mul_hi_nx;
                    p_lo <= mul_lo_nx;
                    cnt  <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        hi      <= mul_hi_nx;
                        lo      <= mul_lo_nx;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        alu_req <= 1'b0;
                        state   <= S_DONE;
                    end
                end
`ifdef MULDIV_DIV_EN
                S_DIV_CMP: begin
                    r     <= {r[WIDTH-2:0], q[WIDTH-1]};
                    ovf   <= r[WIDTH-1];
                    lt    <= alu_result[0];
                    q     <= {q[WIDTH-2:0], 1'b0};
                    state <= S_DIV_SUB;
                end
                S_DIV_SUB: begin
                    r   <= r_nx;
                    q   <= q_nx;
                    cnt <= cnt + 5'd1;
                    if (cnt == CNT_LAST) begin
                        hi      <= r_nx;
                        lo      <= q_nx;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        alu_req <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_DIV_CMP;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;
    localparam logic [3:0] SLT = 4'b0111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        alu_req;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val),
        .alu_req(alu_req), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Shared EX-stage ALU.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ADD: alu_result = alu_a + alu_b;
            SUB: alu_result = alu_a - alu_b;
            SLT: alu_result = {31'b0, (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: result from plain arithmetic, timing as a cycle budget.
    int          m_left = 0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_div = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] p_hi = '0;
    logic [31:0] p_lo = '0;
    logic [31:0] m_opb = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0; m_busy = 1'b0; m_done = 1'b0; m_div = 1'b0;
            m_hi = '0; m_lo = '0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_hi = p_hi; m_lo = p_lo;
                end
            end else if (start) begin
                m_opb = op ? rt_val : rs_val;
                if (!op) begin
                    {p_hi, p_lo} = 64'(rs_val) * 64'(rt_val);
                    m_left = 32; m_busy = 1'b1; m_div = 1'b0;
                end
`ifdef MULDIV_DIV_EN
                else if (rt_val == 0) begin
                    m_hi = rs_val; m_lo = 32'hFFFF_FFFF; m_done = 1'b1;
                end else begin
                    p_hi = rs_val % rt_val; p_lo = rs_val / rt_val;
                    m_left = 64; m_busy = 1'b1; m_div = 1'b1;
                end
`else
                else begin
                    m_hi = '0; m_lo = '0; m_done = 1'b1;
                end
`endif
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("alu_req", alu_req, m_busy);
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        if (!m_busy) begin
            chk("alu_a_idle", alu_a, 0);
            chk("alu_b_idle", alu_b, 0);
            chk("alu_ctrl_idle", alu_ctrl, 0);
        end else if (!m_div) begin
            chk("alu_ctrl_mul", alu_ctrl, ADD);
            chk("alu_b_mul", (alu_b == 0) || (alu_b == m_opb), 1);
        end else begin
            chk("alu_ctrl_div", alu_ctrl, (m_left % 2 == 0) ? SLT : SUB);
            chk("alu_b_div", alu_b, m_opb);
        end
    end

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input int elat, input int ereq, input string tag);
        int n;
        int reqs;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        n = 1; reqs = 0;
        while (!done && n < 200) begin
            if (alu_req) reqs++;
            @(negedge clk);
            n++;
        end
        chk({tag, "_latency"}, n, elat);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        chk({tag, "_alu_req_cycles"}, reqs, ereq);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        #2 reset = 1'b0;
        @(negedge clk);

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 32, "mul_max");
`ifdef MULDIV_DIV_EN
        run_op(1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 65, 64, "div_100_7");
        run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1, 65, 64, "div_ovf");
        run_op(1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0, "div_zero");
`else
        run_op(1'b1, 32'd9, 32'd3, 32'd0, 32'd0, 1, 0, "div_off");
`endif
        run_op(1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 33, 32, "mul_7_6");
        run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 33, 32, "mul_2p16");

        // start pulsed mid-operation is ignored; start held in DONE chains the next op
        start = 1'b1; op = 1'b0; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            if (n == 10) begin
                start = 1'b1; op = 1'b1; rs_val = 32'd77; rt_val = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        chk("ignore_latency", n, 33);
        chk("ignore_lo", lo, 30);
        chk("ignore_hi", hi, 0);
        start = 1'b1; op = 1'b0; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_latency", n, 33);
        chk("b2b_lo", lo, 12);

        // reset in the middle of an operation
`ifdef MULDIV_DIV_EN
        start = 1'b1; op = 1'b1; rs_val = 32'd1000; rt_val = 32'd3;
`else
        start = 1'b1; op = 1'b0; rs_val = 32'd1000; rt_val = 32'd3;
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_alu_req", alu_req, 0);
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_hi", hi, 0);
        chk("midrst_lo", lo, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        n = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) n++;
        end
        chk("midrst_no_done", n, 0);
        run_op(1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 33, 32, "mul_after_rst");

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Iterative unsigned multiply/divide controller for the MIPS pipeline.
- Executes MULTU and DIVU by time-sharing the existing 32-bit combinational ALU: one ALU operation per cycle, with HI/LO produced at the end.
- Sits beside the EX stage. While `alu_req` is high, the EX-stage operand/control mux hands the ALU to this block, and `busy` stalls the pipeline.

## Interface

**Parameters**
- `WIDTH`, 32: operand width; must equal the ALU width.
- `ALU_ADD`, 4'b0010: ALU control code for add.
- `ALU_SUB`, 4'b0110: ALU control code for subtract.
- `ALU_SLT`, 4'b0111: ALU control code for set-less-than (unsigned compare, result 1/0).

**Ports**
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  operation request, sampled at the rising edge.
- `op`  in  1  0 = MULTU, 1 = DIVU.
- `rs_val`  in  WIDTH  multiplicand / dividend.
- `rt_val`  in  WIDTH  multiplier / divisor.
- `alu_req`  out  1  block owns the ALU this cycle.
- `alu_a`  out  WIDTH  ALU operand A.
- `alu_b`  out  WIDTH  ALU operand B.
- `alu_ctrl`  out  4  ALU control.
- `alu_result`  in  WIDTH  ALU result, consumed in the same cycle.
- `busy`  out  1  operation in progress (pipeline stall).
- `done`  out  1  one-cycle pulse: `hi`/`lo` hold the new result.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.

## Operation

**States:** IDLE, MUL, DIV_CMP, DIV_SUB, DONE. A 5-bit iteration counter `cnt` runs alongside.

**Accepting a request**
- `start` is accepted only in IDLE or DONE. It is ignored in MUL, DIV_CMP and DIV_SUB.

**Multiply (`op` = 0)**
- On accept, latch `M = rs_val`, `P_lo = rt_val`, `P_hi = 0`, `cnt = 0`, then go to MUL.
- Each MUL cycle:
  - Drive `alu_a = P_hi`, `alu_b = M` when `P_lo[0] = 1`, else `alu_b = 0`; `alu_ctrl = ALU_ADD`.
  - Compute `carry = (alu_result < P_hi)` locally.
  - Update `{P_hi, P_lo} = {carry, alu_result, P_lo} >> 1`.
- After 32 MUL cycles go to DONE.

**Divide (`op` = 1)**
- On accept, latch `D = rt_val`, `Q = rs_val`, `R = 0`, `cnt = 0`.
- If `D == 0`, go straight to DONE with `hi = rs_val`, `lo = 32'hFFFFFFFF`.
- DIV_CMP:
  - `Rs = {R[30:0], Q[31]}`, `ovf = R[31]`.
  - Drive `alu_a = Rs`, `alu_b = D`, `alu_ctrl = ALU_SLT`; register `lt = alu_result[0]`.
  - `Q <<= 1`.
- DIV_SUB:
  - Drive `alu_a = Rs`, `alu_b = D`, `alu_ctrl = ALU_SUB`.
  - If `ovf | ~lt`: `R = alu_result`, `Q[0] = 1`. Otherwise `R = Rs` and the result is discarded.
  - Go back to DIV_CMP. After the 32nd DIV_SUB, go to DONE.

**DONE**
- Load `hi`/`lo`: multiply gives `hi = P_hi`, `lo = P_lo`; divide gives `hi = R`, `lo = Q`.
- `done = 1` for this one cycle.
- Next state: IDLE, or a new operation if `start` is high.

**ALU ownership**
- `alu_req` = 1 exactly in MUL, DIV_CMP and DIV_SUB.
- Otherwise `alu_a`, `alu_b` and `alu_ctrl` are all 0.

**Status and outputs**
- `busy` = 1 in MUL, DIV_CMP and DIV_SUB; 0 in IDLE and DONE.
- `hi`/`lo` change only on entry to DONE and otherwise hold their value.

**Reset**
- Any time, including mid-operation: state IDLE, `cnt = 0`, all outputs and internal registers 0.
- A partial result is never written to `hi`/`lo`.

## Timing

- `start` is sampled at edge T0.
- MULTU: `done` is high in cycle T0+33 (32 MUL cycles followed by DONE).
- DIVU: `done` is high in cycle T0+65.
- DIVU with divisor 0: `done` is high in cycle T0+1.
- `busy` rises in the cycle after T0 and falls in the DONE cycle.
- ALU path is combinational within a cycle: `alu_*` outputs → ALU → `alu_result` → internal registers. No registered ALU latency.
- Back-to-back operations: `start` held high in the DONE cycle launches the next operation with no idle cycle.

## Configuration

- `MULDIV_DIV_EN` defined: DIVU supported as described.
- `MULDIV_DIV_EN` undefined:
  - DIV_CMP, DIV_SUB and the divide registers are removed.
  - An accepted `op = 1` goes directly to DONE with `hi = 0`, `lo = 0`; `done` rises at T0+1 and `alu_req` never asserts.
  - MULTU is unchanged.

## Test plan

1. MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi` = 0xFFFFFFFE, `lo` = 0x00000001; `done` at T0+33; `alu_req` high for exactly 32 cycles.
2. DIVU 100 / 7 → `lo` = 14, `hi` = 2; `done` at T0+65. DIVU 0xFFFFFFFF / 0x80000001 → `lo` = 1, `hi` = 0x7FFFFFFE (exercises the `ovf` path).
3. DIVU 5 / 0 → `hi` = 5, `lo` = 0xFFFFFFFF; `done` at T0+1; `alu_req` stays 0.
4. `start` pulsed at T0+10 of a MULTU → ignored, result unchanged. `start` held high in DONE → second MULTU 3 × 4 gives `lo` = 12 exactly 33 cycles after the first `done`.
5. `reset` asserted at T0+20 of a DIVU → all outputs 0 immediately; no `done`; next MULTU 2 × 3 gives `lo` = 6.
6. Build without `MULDIV_DIV_EN`: DIVU 9 / 3 → `done` at T0+1 with `hi` = `lo` = 0; MULTU 7 × 6 gives `lo` = 42.
